// File: rtl/axi_time_pkg.sv
// Shared time-block definitions: TX trigger FSM states,
// register offsets and control bit positions.
package axi_time_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PULSE = 2'd2
  } tx_state_t;

  localparam logic [7:0] ADDR_TIME_TX_TRIG_LOW  = 8'h18;
  localparam logic [7:0] ADDR_TIME_TX_TRIG_HIGH = 8'h19;
  localparam logic [7:0] ADDR_TIME_TX_CAPT_LOW  = 8'h1A;
  localparam logic [7:0] ADDR_TIME_TX_CAPT_HIGH = 8'h1B;

  localparam int CTRL_ARM_BIT        = 0;
  localparam int CTRL_DISARM_BIT     = 1;
  localparam int CTRL_STATUS_CLR_BIT = 2;

endpackage

// File: rtl/axi_time_tx_capt.sv
// TX start edge detector and timestamp capture register.
// Used by axi_time_tx_trig when AXI_TIME_TX_CAPT_EN is defined.
module axi_time_tx_capt #(
  parameter int TIME_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] time_cnt,
  input  logic              tx_start,
  input  logic              status_clr,
  output logic [TIME_W-1:0] capt_time,
  output logic              capt_valid
);

  logic start_q;
  logic start_rise;

  assign start_rise = tx_start & ~start_q;

  // Edge register, last-edge-wins capture, sticky valid (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q    <= 1'b0;
      capt_time  <= '0;
      capt_valid <= 1'b0;
    end else begin
      start_q <= tx_start;
      if (start_rise) begin
        capt_time  <= time_cnt;
        capt_valid <= 1'b1;
      end else if (status_clr) begin
        capt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_time_tx_trig.sv
// TX trigger: fires a PULSE_W-cycle tx_trig when time_cnt reaches
// the armed trigger time. TX start capture under AXI_TIME_TX_CAPT_EN.
module axi_time_tx_trig
  import axi_time_pkg::*;
#(
  parameter int TIME_W  = 64,
  parameter int PULSE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] time_cnt,
  input  logic              time_valid,
  input  logic [TIME_W-1:0] trig_time,
  input  logic              arm,
  input  logic              disarm,
  input  logic              status_clr,
  input  logic              tx_start,
  output logic              tx_trig,
  output logic              armed,
  output logic              busy,
  output logic              late,
  output logic [TIME_W-1:0] tx_capt_time,
  output logic              tx_capt_valid
);

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);

  tx_state_t         state, state_nxt;
  logic [TIME_W-1:0] trig_reg, trig_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              late_set;
  logic              is_late;
  logic              match;

  assign is_late = time_valid && (trig_time <= time_cnt);
  assign match   = time_valid && (time_cnt >= trig_reg);

  // Next state: arm/re-arm with late check, disarm, match, pulse count
  always_comb begin
    state_nxt = state;
    trig_nxt  = trig_reg;
    cnt_nxt   = cnt;
    late_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm && !disarm) begin
          trig_nxt = trig_time;
          if (is_late) begin
            late_set  = 1'b1;
            state_nxt = PULSE;
            cnt_nxt   = PULSE_LAST;
          end else begin
            state_nxt = ARMED;
          end
        end
      end
      ARMED: begin
        if (disarm) begin
          state_nxt = IDLE;
        end else if (arm) begin
          trig_nxt = trig_time;
          if (is_late) begin
            late_set  = 1'b1;
            state_nxt = PULSE;
            cnt_nxt   = PULSE_LAST;
          end
        end else if (match) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LAST;
        end
      end
      PULSE: begin
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, trigger time, pulse counter and sticky late flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      trig_reg <= '0;
      cnt      <= '0;
      late     <= 1'b0;
    end else begin
      state    <= state_nxt;
      trig_reg <= trig_nxt;
      cnt      <= cnt_nxt;
      if (late_set) begin
        late <= 1'b1;
      end else if (status_clr) begin
        late <= 1'b0;
      end
    end
  end

  assign tx_trig = (state == PULSE);
  assign armed   = (state == ARMED);
  assign busy    = (state == ARMED) || (state == PULSE);

`ifdef AXI_TIME_TX_CAPT_EN
  axi_time_tx_capt #(
    .TIME_W (TIME_W)
  ) u_capt (
    .clk        (clk),
    .rst        (rst),
    .time_cnt   (time_cnt),
    .tx_start   (tx_start),
    .status_clr (status_clr),
    .capt_time  (tx_capt_time),
    .capt_valid (tx_capt_valid)
  );
`else
  logic unused_tx_start;
  assign unused_tx_start = tx_start;
  assign tx_capt_time    = '0;
  assign tx_capt_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_axi_time_tx_trig.sv
// Bench for axi_time_tx_trig: expected pulses queued by stimulus,
// checked by a tx_trig monitor; state flags checked inline.
module tb_axi_time_tx_trig;

  localparam int TIME_W  = 64;
  localparam int PULSE_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [TIME_W-1:0] time_cnt;
  logic              time_valid;
  logic [TIME_W-1:0] trig_time;
  logic              arm;
  logic              disarm;
  logic              status_clr;
  logic              tx_start;
  logic              tx_trig;
  logic              armed;
  logic              busy;
  logic              late;
  logic [TIME_W-1:0] tx_capt_time;
  logic              tx_capt_valid;

  typedef struct {
    logic [63:0] t_rise;
    logic        late;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  axi_time_tx_trig #(
    .TIME_W  (TIME_W),
    .PULSE_W (PULSE_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .time_cnt      (time_cnt),
    .time_valid    (time_valid),
    .trig_time     (trig_time),
    .arm           (arm),
    .disarm        (disarm),
    .status_clr    (status_clr),
    .tx_start      (tx_start),
    .tx_trig       (tx_trig),
    .armed         (armed),
    .busy          (busy),
    .late          (late),
    .tx_capt_time  (tx_capt_time),
    .tx_capt_valid (tx_capt_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    arm        = 1'b0;
    disarm     = 1'b0;
    status_clr = 1'b0;
    time_cnt   = time_cnt + 64'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input logic [63:0] t);
    int guard;
    guard = 0;
    while (time_cnt != t && guard < 2000) begin
      tick();
      guard++;
    end
    if (time_cnt != t) begin
      checks++;
      errors++;
      $display("FAIL run_until act=%0h exp=%0h", time_cnt, t);
    end
  endtask

  task automatic do_arm(input logic [63:0] t);
    trig_time = t;
    arm       = 1'b1;
  endtask

  // Monitor: each tx_trig pulse must match a queued expectation
  logic        in_pulse = 1'b0;
  int          width = 0;
  exp_t        cur;
  always @(negedge clk) begin
    if (tx_trig && !in_pulse) begin
      in_pulse = 1'b1;
      width    = 1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse act=%0h exp=none", time_cnt);
      end else begin
        cur = q.pop_front();
        chk("rise_time", time_cnt, cur.t_rise);
        chk("rise_late", 64'(late), 64'(cur.late));
        chk("rise_busy", 64'(busy), 64'd1);
      end
    end else if (tx_trig) begin
      width++;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      if (!rst) begin
        chk("pulse_width", 64'(width), 64'(PULSE_W));
        chk("busy_after", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    time_cnt   = '0;
    time_valid = 1'b1;
    trig_time  = '0;
    arm        = 1'b0;
    disarm     = 1'b0;
    status_clr = 1'b0;
    tx_start   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {59'd0, tx_trig, armed, busy, late, tx_capt_valid}, 64'd0);
    chk("rst_capt", tx_capt_time, 64'd0);
    rst = 1'b0;
    tick();

    // 1: on-time trigger at 110
    time_cnt = 64'd100;
    do_arm(64'd110);
    q.push_back('{t_rise: 64'd111, late: 1'b0});
    tick();
    chk("t1_armed", 64'(armed), 64'd1);
    run_until(64'd110);
    ticks(8);
    chk("t1_late", 64'(late), 64'd0);

    // 2: late arm fires at once, status_clr clears late
    time_cnt = 64'd100;
    do_arm(64'd50);
    q.push_back('{t_rise: 64'd101, late: 1'b1});
    ticks(7);
    chk("t2_late_set", 64'(late), 64'd1);
    status_clr = 1'b1;
    tick();
    chk("t2_late_clr", 64'(late), 64'd0);

    // boundary: trig_time equal to time_cnt counts as late
    time_cnt = 64'd300;
    do_arm(64'd300);
    q.push_back('{t_rise: 64'd301, late: 1'b1});
    ticks(7);
    status_clr = 1'b1;
    tick();

    // 3: disarm before match
    time_cnt = 64'd100;
    do_arm(64'd200);
    tick();
    run_until(64'd150);
    disarm = 1'b1;
    tick();
    chk("t3_armed", 64'(armed), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    run_until(64'd300);

    // 4: re-arm earlier replaces the trigger time
    time_cnt = 64'd100;
    do_arm(64'd200);
    tick();
    run_until(64'd170);
    do_arm(64'd180);
    q.push_back('{t_rise: 64'd181, late: 1'b0});
    tick();
    chk("t4_rearmed", 64'(armed), 64'd1);
    run_until(64'd220);

    // 5a: forward jump past trigger
    time_cnt = 64'd100;
    do_arm(64'd200);
    tick();
    run_until(64'd150);
    time_cnt = 64'd250;
    q.push_back('{t_rise: 64'd251, late: 1'b0});
    ticks(8);

    // 5b: backward jump stays armed
    time_cnt = 64'd100;
    do_arm(64'd200);
    tick();
    run_until(64'd150);
    time_cnt = 64'd50;
    tick();
    chk("t5_back_armed", 64'(armed), 64'd1);
    ticks(5);
    chk("t5_still_armed", 64'(armed), 64'd1);
    disarm = 1'b1;
    tick();
    chk("t5_disarmed", 64'(armed), 64'd0);

    // 6: TX start capture
    time_cnt = 64'h1_0000_0005;
    tx_start = 1'b1;
    tick();
`ifdef AXI_TIME_TX_CAPT_EN
    chk("t6_capt_time", tx_capt_time, 64'h1_0000_0005);
    chk("t6_capt_valid", 64'(tx_capt_valid), 64'd1);
`else
    chk("t6_capt_time", tx_capt_time, 64'd0);
    chk("t6_capt_valid", 64'(tx_capt_valid), 64'd0);
`endif
    tx_start = 1'b0;
    tick();

    // 6b: reset mid-pulse
    time_cnt = 64'd100;
    do_arm(64'd50);
    q.push_back('{t_rise: 64'd101, late: 1'b1});
    ticks(2);
    chk("t6_in_pulse", 64'(tx_trig), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", {59'd0, tx_trig, armed, busy, late, tx_capt_valid}, 64'd0);
    chk("t6_rst_capt", tx_capt_time, 64'd0);
    ticks(2);
    rst = 1'b0;
    ticks(8);
    chk("t6_no_resume", 64'(busy), 64'd0);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
